// File: rtl/edge_stream_if.sv
// Pixel-in / edge-map-out stream bundle for edge_stream.
// The threshold rides along with the stream that it qualifies.
`timescale 1ns/1ps
interface edge_stream_if #(
  parameter int PIX_W = 8
);
  localparam int GW = PIX_W + 3;

  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_pixel;
  logic [GW-1:0]    thr;
  logic             out_valid;
  logic             out_sof;
  logic             out_eol;
  logic [PIX_W-1:0] out_pixel;

  modport master (
    output in_valid, in_sof, in_pixel, thr,
    input  out_valid, out_sof, out_eol, out_pixel
  );

  modport slave (
    input  in_valid, in_sof, in_pixel, thr,
    output out_valid, out_sof, out_eol, out_pixel
  );
endinterface

// File: rtl/edge_stream.sv
// Streaming 3x3 Sobel edge detector with internal line buffers.
// Define EDGE_NMS_EN to add non-maximum suppression on magnitude.
`timescale 1ns/1ps
module edge_stream #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  edge_stream_if.slave st
);
  localparam int GW = PIX_W + 3;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO = XW'(2);
  localparam logic [YW-1:0] Y_TWO = YW'(2);

  logic [XW-1:0] x, cx;
  logic [YW-1:0] y, cy;

  assign cx = st.in_sof ? '0 : x;
  assign cy = st.in_sof ? '0 : y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (st.in_valid) begin
      if (cx == X_LAST) begin
        x <= '0;
        y <= (cy == Y_LAST) ? '0 : cy + 1'b1;
      end else begin
        x <= cx + 1'b1;
        y <= cy;
      end
    end
  end

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] win [3][3];
  logic             v0, v1, v2;
  logic             sof0, sof1, sof2;
  logic             eol0, eol1, eol2;
  logic [GW-1:0]    gx1, gy1, mag2;
  logic [GW-1:0]    e_sum, w_sum, n_sum, s_sum;
  logic [GW-1:0]    ax, ay;

  // Row 0 is two lines up (N), column 2 is the newest pixel (E).
  always_ff @(posedge clk) begin
    if (st.in_valid) begin
      lb1[cx] <= lb0[cx];
      lb0[cx] <= st.in_pixel;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[cx];
      win[1][2] <= lb0[cx];
      win[2][2] <= st.in_pixel;
    end
  end

  assign w_sum = GW'(win[0][0]) + (GW'(win[1][0]) << 1)
               + GW'(win[2][0]);
  assign e_sum = GW'(win[0][2]) + (GW'(win[1][2]) << 1)
               + GW'(win[2][2]);
  assign n_sum = GW'(win[0][0]) + (GW'(win[0][1]) << 1)
               + GW'(win[0][2]);
  assign s_sum = GW'(win[2][0]) + (GW'(win[2][1]) << 1)
               + GW'(win[2][2]);

  assign ax = gx1[GW-1] ? -gx1 : gx1;
  assign ay = gy1[GW-1] ? -gy1 : gy1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v0 <= st.in_valid && cx >= X_TWO && cy >= Y_TWO;
      v1 <= v0;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    sof0 <= cx == X_TWO && cy == Y_TWO;
    eol0 <= cx == X_LAST;
    sof1 <= sof0;
    eol1 <= eol0;
    gx1  <= e_sum - w_sum;
    gy1  <= s_sum - n_sum;
    sof2 <= sof1;
    eol2 <= eol1;
    mag2 <= ax + ay;
  end

`ifdef EDGE_NMS_EN
  localparam int MW  = IMG_W - 2;
  localparam int MXW = $clog2(MW);
  localparam int MYW = $clog2(IMG_H - 2);
  localparam int EW  = GW + 2;
  localparam logic [MXW-1:0] MX_LAST = MXW'(IMG_W - 3);
  localparam logic [MYW-1:0] MY_LAST = MYW'(IMG_H - 3);
  localparam logic [MXW-1:0] MX_TWO = MXW'(2);
  localparam logic [MYW-1:0] MY_TWO = MYW'(2);
  localparam logic [1:0] BIN_H  = 2'd0;
  localparam logic [1:0] BIN_V  = 2'd1;
  localparam logic [1:0] BIN_D1 = 2'd2;
  localparam logic [1:0] BIN_D2 = 2'd3;

  logic [GW+2:0]  ax2, ay2, ax5, ay5;
  logic           h_dir, v_dir, same_sg;
  logic [1:0]     bin, bin2, cbin;
  logic [MXW-1:0] mx, mcx;
  logic [MYW-1:0] my, mcy;
  logic [EW-1:0]  mlb0 [MW];
  logic [EW-1:0]  mlb1 [MW];
  logic [EW-1:0]  mwin [3][3];
  logic           mv0, msof0, meol0;
  logic           mv1, msof1, meol1, medge1;
  logic [GW-1:0]  cmag, na, nb;

  assign ax2 = {2'b0, ax, 1'b0};
  assign ay2 = {2'b0, ay, 1'b0};
  assign ax5 = {1'b0, ax, 2'b0} + {3'b0, ax};
  assign ay5 = {1'b0, ay, 2'b0} + {3'b0, ay};
  assign h_dir   = ay5 < ax2;
  assign v_dir   = ax5 < ay2;
  assign same_sg = gx1[GW-1] == gy1[GW-1];

  always_comb begin
    bin = BIN_D2;
    unique case (1'b1)
      h_dir:                      bin = BIN_H;
      v_dir:                      bin = BIN_V;
      !h_dir && !v_dir && same_sg: bin = BIN_D1;
      default:                    bin = BIN_D2;
    endcase
  end

  always_ff @(posedge clk) bin2 <= bin;

  // Interior samples get their own raster counters and line buffers.
  assign mcx = sof2 ? '0 : mx;
  assign mcy = sof2 ? '0 : my;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx  <= '0;
      my  <= '0;
      mv0 <= 1'b0;
      mv1 <= 1'b0;
    end else begin
      mv0 <= v2 && mcx >= MX_TWO && mcy >= MY_TWO;
      mv1 <= mv0;
      if (v2) begin
        if (mcx == MX_LAST) begin
          mx <= '0;
          my <= (mcy == MY_LAST) ? '0 : mcy + 1'b1;
        end else begin
          mx <= mcx + 1'b1;
          my <= mcy;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (v2) begin
      mlb1[mcx] <= mlb0[mcx];
      mlb0[mcx] <= {bin2, mag2};
      for (int r = 0; r < 3; r++) begin
        mwin[r][0] <= mwin[r][1];
        mwin[r][1] <= mwin[r][2];
      end
      mwin[0][2] <= mlb1[mcx];
      mwin[1][2] <= mlb0[mcx];
      mwin[2][2] <= {bin2, mag2};
    end
  end

  assign cmag = mwin[1][1][GW-1:0];
  assign cbin = mwin[1][1][EW-1:GW];

  always_comb begin
    na = mwin[1][0][GW-1:0];
    nb = mwin[1][2][GW-1:0];
    unique case (cbin)
      BIN_H: begin
        na = mwin[1][0][GW-1:0];
        nb = mwin[1][2][GW-1:0];
      end
      BIN_V: begin
        na = mwin[0][1][GW-1:0];
        nb = mwin[2][1][GW-1:0];
      end
      BIN_D1: begin
        na = mwin[0][0][GW-1:0];
        nb = mwin[2][2][GW-1:0];
      end
      BIN_D2: begin
        na = mwin[0][2][GW-1:0];
        nb = mwin[2][0][GW-1:0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    msof0  <= mcx == MX_TWO && mcy == MY_TWO;
    meol0  <= mcx == MX_LAST;
    msof1  <= msof0;
    meol1  <= meol0;
    medge1 <= cmag > st.thr && cmag >= na && cmag >= nb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st.out_valid <= 1'b0;
      st.out_sof   <= 1'b0;
      st.out_eol   <= 1'b0;
      st.out_pixel <= '0;
    end else begin
      st.out_valid <= mv1;
      st.out_sof   <= mv1 && msof1;
      st.out_eol   <= mv1 && meol1;
      if (mv1) st.out_pixel <= {PIX_W{medge1}};
    end
  end
`else
  logic edge2;

  assign edge2 = mag2 > st.thr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st.out_valid <= 1'b0;
      st.out_sof   <= 1'b0;
      st.out_eol   <= 1'b0;
      st.out_pixel <= '0;
    end else begin
      st.out_valid <= v2;
      st.out_sof   <= v2 && sof2;
      st.out_eol   <= v2 && eol2;
      if (v2) st.out_pixel <= {PIX_W{edge2}};
    end
  end
`endif
endmodule

// File: tb/tb_edge_stream.sv
// Directed bench for edge_stream: flat, step, threshold ties, gaps,
// mid-frame restart and asynchronous reset on small frames.
`timescale 1ns/1ps
module tb_edge_stream;
  localparam int W  = 8;
  localparam int PW = 8;
  localparam int GW = PW + 3;
`ifdef EDGE_NMS_EN
  localparam int H   = 8;
  localparam int B   = 4;
  localparam int LAT = 6;
`else
  localparam int H   = 6;
  localparam int B   = 2;
  localparam int LAT = 4;
`endif

  typedef struct {
    logic [31:0] pix;
    logic        sof;
    logic        eol;
    int          cyc;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    cyc = 0;
  int    nasrt = 0;
  int    nfail = 0;
  beat_t expq[$];
  beat_t gotq[$];

  edge_stream_if #(.PIX_W(PW)) ifc ();

  edge_stream #(
    .IMG_W(W),
    .IMG_H(H),
    .PIX_W(PW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .st(ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (ifc.out_valid === 1'b1)
      gotq.push_back('{32'(ifc.out_pixel), ifc.out_sof,
                       ifc.out_eol, cyc});

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nasrt++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pix_at(input int pat, input int x);
    if (pat == 0) return 100;
    return (x >= 4) ? 200 : 0;
  endfunction

  // Step edge between columns 3|4: centres 3 and 4 see |Gx| = 4*200.
  function automatic int exp_at(input int pat, input int xc,
                                input int thr);
    int mag;
    mag = (pat == 1 && (xc == 3 || xc == 4)) ? 800 : 0;
    return (mag > thr) ? 255 : 0;
  endfunction

  task automatic run(input int n, input int pat, input int gap,
                     input bit sof_first, input int thr);
    int x;
    int y;
    for (int i = 0; i < n; i++) begin
      x = i % W;
      y = (i / W) % H;
      @(negedge clk);
      ifc.thr      = GW'(thr);
      ifc.in_valid = 1'b1;
      ifc.in_sof   = sof_first && i == 0;
      ifc.in_pixel = PW'(pix_at(pat, x));
      if (x >= B && y >= B)
        expq.push_back('{32'(exp_at(pat, x - B / 2, thr)),
                         x == B && y == B, x == W - 1, cyc + LAT});
      repeat (gap) begin
        @(negedge clk);
        ifc.in_valid = 1'b0;
        ifc.in_sof   = 1'b0;
      end
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_sof   = 1'b0;
  endtask

  task automatic drain_cmp(input string tag);
    repeat (LAT + 2) @(negedge clk);
    chk({tag, ".count"}, gotq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      chk($sformatf("%s.pix[%0d]", tag, i), gotq[i].pix, expq[i].pix);
      chk($sformatf("%s.sof[%0d]", tag, i), gotq[i].sof, expq[i].sof);
      chk($sformatf("%s.eol[%0d]", tag, i), gotq[i].eol, expq[i].eol);
      chk($sformatf("%s.cyc[%0d]", tag, i), gotq[i].cyc, expq[i].cyc);
    end
    expq.delete();
    gotq.delete();
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, ".valid"}, ifc.out_valid, 0);
    chk({tag, ".sof"},   ifc.out_sof,   0);
    chk({tag, ".eol"},   ifc.out_eol,   0);
    chk({tag, ".pixel"}, ifc.out_pixel, 0);
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_sof   = 1'b0;
    ifc.in_pixel = '0;
    ifc.thr      = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_outs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(W * H, 0, 0, 1'b1, 0);
    drain_cmp("flat");
    run(W * H, 1, 0, 1'b0, 100);
    drain_cmp("step_wrap");
    run(W * H, 1, 0, 1'b1, 800);
    drain_cmp("thr_tie");
    run(W * H, 1, 0, 1'b1, 799);
    drain_cmp("thr_below");
    run(W * H, 1, 3, 1'b1, 100);
    drain_cmp("gaps");
    run(19, 0, 0, 1'b1, 0);
    run(W * H, 1, 0, 1'b1, 100);
    drain_cmp("restart");

    // Last beat (5,4) yields an edge pixel still in the output register.
    run(4 * W + 6, 1, 0, 1'b1, 100);
    repeat (LAT - 1) @(negedge clk);
    chk("pre_rst.valid", ifc.out_valid, 1);
    chk("pre_rst.pixel", ifc.out_pixel, 255);
    #2 rst_n = 1'b0;
    #1 chk_outs_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain_cmp("pre_rst");
    run(W * H, 1, 0, 1'b0, 100);
    drain_cmp("post_rst_step");
    run(W * H, 0, 0, 1'b0, 0);
    drain_cmp("post_rst_flat");

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
